// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall control at the consuming end of the ID->EX pipeline
//   register. It detects load-use hazards and tracks how long the multi-cycle
//   MULT/DIV unit is occupied. A detected hazard freezes the PC and IF/ID and
//   injects a bubble into ID/EX in the same cycle.
//
//   Parameters
//     REG_ADDR_W  register address width
//     MD_LAT      MULT/DIV busy cycles after issue in EX (>= 2)
//     CNT_W       busy counter width, must hold MD_LAT-1
//
//   Ports
//     clk, reset         rising-edge clock, synchronous active-high reset
//     rs_addr_id/rt_addr_id, use_rs_id/use_rt_id   ID-stage source operands
//     md_start_id, hilo_read_id                    ID is MULT/DIV or MFHI/MFLO
//     mem_read_ex, rt_addr_ex                      EX-stage load + destination
//     md_start_ex                                  MULT/DIV issued in EX
//     stall_pc, stall_if_id, bubble_id_ex          combinational stall outputs
//     md_busy                                      MULT/DIV unit occupied
//     md_done                                      1-cycle pulse, HI/LO valid next
//
//   Optional feature (macro HAZARD_STATS_EN)
//     Adds stall_cnt[31:0] (cycles stalled) and md_cnt_total[31:0] (MULT/DIV
//     issues accepted). Both saturate and clear on reset.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_addr_id,
  input  logic [REG_ADDR_W-1:0] rt_addr_id,
  input  logic                  use_rs_id,
  input  logic                  use_rt_id,
  input  logic                  md_start_id,
  input  logic                  hilo_read_id,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rt_addr_ex,
  input  logic                  md_start_ex,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  md_busy,
  output logic                  md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           md_cnt_total
`endif
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  // The counter runs MD_LAT-1 down to 0, so the unit is busy for exactly
  // MD_LAT cycles and md_done lands on the first cycle back in IDLE.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             done_q, done_d;

  logic load_use;
  logic md_hzd;
  logic stall;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (md_start_ex) begin
          state_d  = ST_MD_BUSY;
          md_cnt_d = CNT_LOAD;
        end
      end
      ST_MD_BUSY: begin
        // A second issue while busy is illegal and deliberately ignored:
        // the counter is not reloaded.
        if (md_cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      md_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and outputs (all forced low while reset is asserted)
  // ---------------------------------------------------------------------------
  assign md_busy = (state_q == ST_MD_BUSY) & ~reset;
  assign md_done = done_q & ~reset;

  // Register $zero is never a true dependency.
  assign load_use = mem_read_ex & (rt_addr_ex != '0) &
                    ((use_rs_id & (rs_addr_id == rt_addr_ex)) |
                     (use_rt_id & (rt_addr_id == rt_addr_ex)));

  assign md_hzd = md_busy & (hilo_read_id | md_start_id);

  // Both hazards collapse onto one stall line, so a coincident pair still
  // produces a single bubble per cycle.
  assign stall        = ~reset & (load_use | md_hzd);
  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] md_total_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      md_total_q  <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state_q == ST_IDLE) && md_start_ex && (md_total_q != '1)) begin
        md_total_q <= md_total_q + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_cnt_total = md_total_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_MD_BUSY) && md_start_ex) begin
      $display("hazard_ctrl: error: md_start_ex while MULT/DIV busy, ignored");
    end
  end
`endif

endmodule
